// File: rtl/osd_stm_multi.sv
// Multi-channel system trace capture: per-channel timestamped FIFOs with in-band
// overflow records, merged round-robin into a single registered event stream.
module osd_stm_multi #(
  parameter int XLEN  = 64,
  parameter int NCH   = 4,
  parameter int DEPTH = 4,
  parameter int TSW   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           chan_enable,
  input  logic                     stall,
  input  logic [NCH-1:0]           trace_valid,
  input  logic [NCH*16-1:0]        trace_id,
  input  logic [NCH*XLEN-1:0]      trace_value,
  output logic [XLEN+16+TSW-1:0]   out_data,
  output logic                     out_overflow,
  output logic [3:0]               out_chan,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int EW = XLEN + 16 + TSW;
  localparam int AW = $clog2(DEPTH);

  logic [TSW-1:0] ts_q;
  logic [15:0]    empty_s;
  logic [EW:0]    head_s [16];
  logic [NCH-1:0] pop_s;
  logic           grant_en_s;
  logic           gnt_found_s;
  logic [3:0]     gnt_idx_s;
  logic [EW:0]    gnt_head_s;
  logic [3:0]     ptr_q, ptr_d;
  logic           out_valid_q;
  logic [EW-1:0]  out_data_q;
  logic           out_overflow_q;
  logic [3:0]     out_chan_q;

  // Free-running capture timestamp
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TSW'(1);
    end
  end

  for (genvar c = 0; c < 16; c++) begin : g_ch
    if (c < NCH) begin : g_live
      logic [EW:0]  mem_q [DEPTH];
      logic [AW:0]  wr_q, rd_q;
      logic [15:0]  lost_q, lost_d;
      logic         full_s, accept_s, room_s, we_s;
      logic [EW:0]  wdata_s;

      assign full_s      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      assign empty_s[c]  = (wr_q == rd_q);
      assign head_s[c]   = mem_q[rd_q[AW-1:0]];
      assign accept_s    = trace_valid[c] & chan_enable[c] & ~stall;
      // A same-cycle pop frees the slot, so a full FIFO still accepts the write.
      assign room_s      = ~full_s | pop_s[c];

      // Write-slot selection: pending overflow record has priority over samples
      always_comb begin
        we_s    = 1'b0;
        wdata_s = '0;
        lost_d  = lost_q;
        if ((lost_q != 16'h0000) && room_s) begin
          we_s    = 1'b1;
          wdata_s = {1'b1, {XLEN{1'b0}}, lost_q, ts_q};
          lost_d  = accept_s ? 16'h0001 : 16'h0000;
        end else if (accept_s) begin
          if (room_s) begin
            we_s    = 1'b1;
            wdata_s = {1'b0, trace_value[XLEN*c +: XLEN], trace_id[16*c +: 16], ts_q};
          end else if (lost_q != 16'hFFFF) begin
            lost_d = lost_q + 16'h0001;
          end else begin
            lost_d = lost_q;
          end
        end else begin
          lost_d = lost_q;
        end
      end

      // FIFO pointers and lost counter
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_q   <= '0;
          rd_q   <= '0;
          lost_q <= 16'h0000;
        end else begin
          if (we_s) begin
            wr_q <= wr_q + (AW+1)'(1);
          end
          if (pop_s[c]) begin
            rd_q <= rd_q + (AW+1)'(1);
          end
          lost_q <= lost_d;
        end
      end

      // FIFO storage
      always_ff @(posedge clk) begin
        if (we_s) begin
          mem_q[wr_q[AW-1:0]] <= wdata_s;
        end
      end
    end else begin : g_pad
      assign empty_s[c] = 1'b1;
      assign head_s[c]  = '0;
    end
  end

  assign grant_en_s = ~out_valid_q | out_ready;

  // Round-robin search over non-empty FIFOs starting at ptr
  always_comb begin
    logic [4:0] cand;
    logic [4:0] nxt;
    gnt_found_s = 1'b0;
    gnt_idx_s   = 4'd0;
    cand        = 5'd0;
    for (int i = 0; i < NCH; i++) begin
      cand = {1'b0, ptr_q} + 5'(i);
      if (cand >= 5'(NCH)) begin
        cand = cand - 5'(NCH);
      end else begin
        cand = cand;
      end
      if (!gnt_found_s && !empty_s[cand[3:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand[3:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
    nxt = {1'b0, gnt_idx_s} + 5'd1;
    if (nxt >= 5'(NCH)) begin
      ptr_d = 4'd0;
    end else begin
      ptr_d = nxt[3:0];
    end
  end

  // One-hot pop towards the granted channel
  always_comb begin
    pop_s = '0;
    for (int c = 0; c < NCH; c++) begin
      pop_s[c] = grant_en_s & gnt_found_s & (gnt_idx_s == 4'(c));
    end
  end

  assign gnt_head_s = head_s[gnt_idx_s];

  // Output register and arbiter pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_overflow_q <= 1'b0;
      out_chan_q     <= 4'd0;
      ptr_q          <= 4'd0;
    end else if (grant_en_s) begin
      if (gnt_found_s) begin
        out_valid_q    <= 1'b1;
        out_data_q     <= gnt_head_s[EW-1:0];
        out_overflow_q <= gnt_head_s[EW];
        out_chan_q     <= gnt_idx_s;
        ptr_q          <= ptr_d;
      end else begin
        out_valid_q    <= 1'b0;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_overflow = out_overflow_q;
  assign out_chan     = out_chan_q;

endmodule

// File: tb/tb_osd_stm_multi.sv
// Bench for osd_stm_multi: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_osd_stm_multi;
  localparam int XLEN  = 64;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int TSW   = 32;
  localparam int EW    = XLEN + 16 + TSW;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     chan_enable;
  logic               stall;
  logic [NCH-1:0]     trace_valid;
  logic [NCH*16-1:0]  trace_id;
  logic [NCH*XLEN-1:0] trace_value;
  logic [EW-1:0]      out_data;
  logic               out_overflow;
  logic [3:0]         out_chan;
  logic               out_valid;
  logic               out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int             cyc;
    logic [3:0]     chan;
    logic           ovf;
    logic [EW-1:0]  data;
  } rec_t;
  rec_t log_q[$];

  // reference model state
  logic [EW:0]    mq [NCH][$];
  int             m_lost [NCH];
  logic [TSW-1:0] m_ts;
  int             m_ptr;
  logic           m_valid;
  logic [EW-1:0]  m_data;
  logic           m_ovf;
  logic [3:0]     m_chan;

  osd_stm_multi #(.XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH), .TSW(TSW)) dut (
    .clk(clk), .rst(rst), .chan_enable(chan_enable), .stall(stall),
    .trace_valid(trace_valid), .trace_id(trace_id), .trace_value(trace_value),
    .out_data(out_data), .out_overflow(out_overflow), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [15:0] id, input logic [XLEN-1:0] v);
    trace_id[16*c +: 16]       = id;
    trace_value[XLEN*c +: XLEN] = v;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick;
    tick;
    rst = 1'b1;
  endtask

  task automatic model_reset;
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_lost[c] = 0;
    end
    m_ts = '0; m_ptr = 0; m_valid = 1'b0; m_data = '0; m_ovf = 1'b0; m_chan = 4'd0;
  endtask

  // Reference model: queues per channel, arbitration, then capture
  initial begin
    logic [EW:0] e;
    bit found, acc, room;
    int k;
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset();
      end else begin
        if (!m_valid || out_ready) begin
          found = 1'b0;
          for (int i = 0; i < NCH; i++) begin
            k = (m_ptr + i) % NCH;
            if (!found && mq[k].size() > 0) begin
              found = 1'b1;
              e = mq[k].pop_front();
              m_data = e[EW-1:0]; m_ovf = e[EW]; m_chan = 4'(k);
              m_ptr = (k + 1) % NCH;
            end
          end
          m_valid = found;
        end
        for (int c = 0; c < NCH; c++) begin
          acc  = trace_valid[c] && chan_enable[c] && !stall;
          room = mq[c].size() < DEPTH;
          if (m_lost[c] != 0 && room) begin
            mq[c].push_back({1'b1, {XLEN{1'b0}}, 16'(m_lost[c]), m_ts});
            m_lost[c] = acc ? 1 : 0;
          end else if (acc) begin
            if (room) mq[c].push_back({1'b0, trace_value[XLEN*c +: XLEN], trace_id[16*c +: 16], m_ts});
            else if (m_lost[c] < 65535) m_lost[c]++;
          end
        end
        m_ts = m_ts + 1;
      end
    end
  end

  // Every-cycle comparison against the model, plus transfer log
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("out_overflow", out_overflow, m_ovf);
      chk("out_chan", out_chan, m_chan);
      if (rst === 1'b1 && out_valid && out_ready)
        log_q.push_back('{cyc, out_chan, out_overflow, out_data});
    end
  end

  initial begin
    rst = 1'b0; chan_enable = 4'hF; stall = 1'b0; trace_valid = '0;
    trace_id = '0; trace_value = '0; out_ready = 1'b1;
    tick; tick;
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_data", out_data, '0);
    chk("reset_chan", out_chan, 4'd0);
    rst = 1'b1;

    // single sample on ch2 at timestamp 10
    repeat (10) tick;
    set_ch(2, 16'h0005, 64'hAB);
    trace_valid = 4'b0100;
    tick;
    trace_valid = '0;
    tick;
    chk("single_valid", out_valid, 1'b1);
    chk("single_chan", out_chan, 4'd2);
    chk("single_ovf", out_overflow, 1'b0);
    chk("single_data", out_data, {64'hAB, 16'h0005, 32'd10});
    tick;
    chk("single_one_event", out_valid, 1'b0);
    repeat (3) tick;
    chk("single_count", log_q.size(), 1);

    // round robin: all four channels, three samples each
    do_reset();
    log_q.delete();
    trace_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < NCH; c++) set_ch(c, 16'(c), 64'(4 * k + c));
      tick;
    end
    trace_valid = '0;
    repeat (16) tick;
    chk("rr_count", log_q.size(), 12);
    for (int i = 0; i < 12 && i < log_q.size(); i++) begin
      chk("rr_chan", log_q[i].chan, 4'(i % 4));
      chk("rr_value", log_q[i].data[EW-1 -: XLEN], 64'(i));
      chk("rr_cycle", log_q[i].cyc, log_q[0].cyc + i);
    end

    // overflow: output register occupied, ch1 gets 7 samples with out_ready low
    do_reset();
    log_q.delete();
    out_ready = 1'b0;
    set_ch(0, 16'h00A0, 64'hC0);
    trace_valid = 4'b0001;
    tick;
    trace_valid = 4'b0010;
    for (int k = 0; k < 7; k++) begin
      set_ch(1, 16'h0011, 64'(16'h100 + k));
      tick;
    end
    trace_valid = '0;
    tick; tick;
    chk("ovf_hold_valid", out_valid, 1'b1);
    chk("ovf_hold_chan", out_chan, 4'd0);
    out_ready = 1'b1;
    repeat (8) tick;
    set_ch(1, 16'h0011, 64'h200);
    trace_valid = 4'b0010;
    tick;
    trace_valid = '0;
    repeat (5) tick;
    chk("ovf_count", log_q.size(), 7);
    if (log_q.size() == 7) begin
      chk("ovf_first_chan", log_q[0].chan, 4'd0);
      chk("ovf_first_value", log_q[0].data[EW-1 -: XLEN], 64'hC0);
      for (int i = 1; i < 5; i++) begin
        chk("ovf_sample_chan", log_q[i].chan, 4'd1);
        chk("ovf_sample_flag", log_q[i].ovf, 1'b0);
        chk("ovf_sample_value", log_q[i].data[EW-1 -: XLEN], 64'(16'h100 + i - 1));
      end
      chk("ovf_rec_flag", log_q[5].ovf, 1'b1);
      chk("ovf_rec_chan", log_q[5].chan, 4'd1);
      chk("ovf_rec_lost", log_q[5].data[TSW +: 16], 16'd3);
      chk("ovf_rec_value", log_q[5].data[EW-1 -: XLEN], 64'h0);
      chk("ovf_later_flag", log_q[6].ovf, 1'b0);
      chk("ovf_later_value", log_q[6].data[EW-1 -: XLEN], 64'h200);
    end

    // mask then stall: nothing captured, nothing counted as lost
    log_q.delete();
    chan_enable = 4'b1011;
    set_ch(2, 16'h0022, 64'h33);
    trace_valid = 4'b0100;
    repeat (5) tick;
    trace_valid = '0;
    repeat (6) tick;
    chk("mask_no_events", log_q.size(), 0);
    chan_enable = 4'hF;
    stall = 1'b1;
    trace_valid = 4'hF;
    repeat (5) tick;
    trace_valid = '0;
    stall = 1'b0;
    repeat (6) tick;
    chk("stall_no_events", log_q.size(), 0);
    trace_valid = 4'b0100;
    tick;
    trace_valid = '0;
    repeat (4) tick;
    chk("post_stall_count", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("post_stall_ovf", log_q[0].ovf, 1'b0);
      chk("post_stall_chan", log_q[0].chan, 4'd2);
    end

    // backpressure hold, then reset in the middle of it
    do_reset();
    out_ready = 1'b0;
    repeat (3) tick;
    set_ch(3, 16'h0077, 64'h1234);
    trace_valid = 4'b1000;
    tick;
    trace_valid = '0;
    tick;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, {64'h1234, 16'h0077, 32'd3});
      chk("hold_chan", out_chan, 4'd3);
      tick;
    end
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_data", out_data, '0);
    chk("async_rst_chan", out_chan, 4'd0);
    out_ready = 1'b1;
    set_ch(1, 16'h0011, 64'h55);
    trace_valid = 4'b0010;
    tick;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    trace_valid = '0;
    tick;
    chk("restart_valid", out_valid, 1'b1);
    chk("restart_chan", out_chan, 4'd1);
    chk("restart_data", out_data, {64'h55, 16'h0011, 32'd0});
    repeat (3) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/osd_stm_multi.md
# osd_stm_multi

Multi-channel system trace capture front end, the next-generation system trace module, generalised from one trace port to `NCH` independent channels. It timestamps software trace events per channel, buffers each channel in its own FIFO, and accounts for lost events per channel with in-band overflow records. A round-robin arbiter merges all channels into a single registered event stream that feeds trace packetization. Channel masking and a global stall are driven by the module's register layer.

## Interface
- `XLEN`, 64: trace value width.
- `NCH`, 4: channel count, 1..16.
- `DEPTH`, 4: per-channel FIFO depth, power of two, ≥2.
- `TSW`, 32: timestamp width. Event width `EW = XLEN+16+TSW`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `chan_enable`  in  NCH  per-channel capture enable.
- `stall`  in  1  global capture stall from the register layer.
- `trace_valid`  in  NCH  per-channel sample strobe.
- `trace_id`  in  NCH*16  channel c at bits [16c+15:16c].
- `trace_value`  in  NCH*XLEN  channel c at bits [XLEN*c+XLEN-1:XLEN*c].
- `out_data`  out  EW  {value, id, timestamp}.
- `out_overflow`  out  1  entry is an overflow record.
- `out_chan`  out  4  source channel index.
- `out_valid`  out  1  output holds an event.
- `out_ready`  in  1  downstream accepts.

## Operation
- **Timestamp:** a free-running `TSW`-bit counter, 0 after reset, +1 every cycle, wraps to 0. A sample carries the counter value of the cycle in which `trace_valid` is high.
- **Capture:** channel c accepts a sample when `trace_valid[c] & chan_enable[c] & !stall`.
  - Samples rejected by enable or stall are discarded and **not** counted as lost.
  - Disabling a channel does not flush its FIFO; buffered entries still drain.
- **Per-channel FIFO:** `DEPTH` entries of {ovf, EW data}.
- **Lost counter:** 16 bits per channel, saturating at 0xFFFF.
  - An accepted sample arriving with the FIFO full increments the counter.
- **Overflow record:** when the lost counter ≠ 0 and the FIFO is not full, the FIFO write slot is used for an overflow record instead of a sample.
  - Record contents: ovf=1, data = {XLEN'0, lost[15:0], current timestamp}.
  - The counter then clears.
  - An accepted sample in that same cycle is dropped and sets the counter to 1.
  - An overflow record always precedes any newer sample from that channel.
- **Arbiter:** round-robin over channels with non-empty FIFOs.
  - The search starts at `ptr`. `ptr` is 0 after reset; after granting channel k, `ptr = (k+1) mod NCH`.
  - A grant occurs when `!out_valid | out_ready`.
  - The granted head entry is popped and loaded into the output register, along with its channel index. Otherwise the output register holds.
- **FIFO boundaries:**
  - Push and pop on a full FIFO in the same cycle: the push succeeds, with no loss.
  - Pop on empty is impossible by construction.
- **`NCH=1`:** the arbiter degenerates to pass-through; `out_chan` is always 0.

## Timing
- **Reset values:** `out_valid=0`, `out_data=0`, `out_overflow=0`, `out_chan=0`. All FIFOs empty, lost counters 0, timestamp 0, `ptr=0`.
  - Reset assertion clears these immediately, asynchronously, including mid-transfer; in-flight events are lost.
- **Latency:** a sample in cycle t into an empty, idle path gives `out_valid=1` in cycle t+2 (FIFO write at the end of t, output register load at the end of t+1).
- **Handshake:** a transfer completes on a cycle with `out_valid & out_ready`.
  - While `out_valid & !out_ready`, all outputs are stable.
  - Back-to-back transfers sustain 1 event/cycle.
- **Fairness:** with all channels continuously backlogged and `out_ready=1`, each channel gets exactly one grant every `NCH` cycles.
- **Loss bound:** with `out_ready` held low, a channel buffers `DEPTH` samples; further accepted samples increment lost.

## Test plan
- **Single sample:** NCH=4, `out_ready=1`; ch2 sample id=0x0005 value=0xAB at timestamp 10 → cycle t+2: `out_valid=1`, `out_chan=2`, `out_overflow=0`, `out_data={0xAB, 0x0005, 10}`; exactly one event.
- **Round-robin:** ch0..3 each push 3 samples in the same cycles; `out_ready=1` → output channel order 0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles.
- **Overflow:** DEPTH=4, `out_ready=0`; ch1 gets 7 consecutive samples → 4 buffered, lost=3. Release `out_ready` → 4 samples, then an overflow record with `out_overflow=1`, data[TSW+15:TSW]=3, then later samples.
- **Mask and stall:** `chan_enable=4'b1011` and ch2 driven 5 cycles → no ch2 events and no overflow record. Then `stall=1` on all channels for 5 cycles → no events, lost counters remain 0.
- **Backpressure and reset:** hold `out_ready=0` with `out_valid=1` for 10 cycles → `out_data` and `out_chan` stable. Pull `rst` low mid-hold → `out_valid=0` in the same cycle; after release, the first event carries timestamp restarted from 0.
